// File: rtl/demux_1xx_to_40xx_reg.sv
// Registered 1-to-40 scatter buffer: one write stream steered into 40 holding
// slots, each with its own valid bit, per-slot release and live occupancy count.
module demux_1xx_to_40xx_reg #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [5:0]            wr_select,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  wr_ready,
    input  logic [39:0]           consume,
    output logic [40*WIDTH-1:0]   out,
    output logic [39:0]           out_valid,
    output logic [5:0]            occupancy,
    output logic                  err_select
);

    localparam int NSLOT = 40;

    function automatic logic [5:0] popcount40(input logic [NSLOT-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < NSLOT; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    logic [WIDTH-1:0] r_data_p1 [NSLOT];
    logic [NSLOT-1:0] r_valid_p1;
    logic [5:0]       r_occ_p1;
    logic             r_err_p1;

    logic [NSLOT-1:0] w_sel_onehot;
    logic [NSLOT-1:0] w_slot_free;
    logic [NSLOT-1:0] w_wr_hit;
    logic [NSLOT-1:0] w_valid_nxt;
    logic             w_sel_legal;
    logic             w_accept;

    // Out-of-range ids decode to all-zero, so wr_ready falls out low for 40-63.
    always_comb begin
        w_sel_onehot = '0;
        for (int i = 0; i < NSLOT; i++) begin
            w_sel_onehot[i] = (wr_select == 6'(i));
        end
    end

    assign w_sel_legal = (wr_select < 6'd40);
    assign w_slot_free = ~r_valid_p1 | consume;
    assign wr_ready    = |(w_sel_onehot & w_slot_free);
    assign w_accept    = wr_en & wr_ready;
    assign w_wr_hit    = w_sel_onehot & {NSLOT{w_accept}};
    // A same-cycle write wins over a release of the same slot.
    assign w_valid_nxt = (r_valid_p1 & ~consume) | w_wr_hit;

    // ---- stage p1: slot registers, valids, occupancy, error pulse ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_p1 <= '0;
            r_occ_p1   <= '0;
            r_err_p1   <= 1'b0;
        end else begin
            r_valid_p1 <= w_valid_nxt;
            r_occ_p1   <= popcount40(w_valid_nxt);
            r_err_p1   <= wr_en & ~w_sel_legal;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NSLOT; i++) begin
            if (rst) begin
                r_data_p1[i] <= '0;
            end else if (w_wr_hit[i]) begin
                r_data_p1[i] <= wr_data;
            end
        end
    end

    for (genvar g = 0; g < NSLOT; g++) begin : g_out
        assign out[g*WIDTH +: WIDTH] = r_data_p1[g];
    end

    assign out_valid  = r_valid_p1;
    assign occupancy  = r_occ_p1;
    assign err_select = r_err_p1;

endmodule

// File: tb/tb_demux_1xx_to_40xx_reg.sv
// Scoreboard bench for the 40-slot scatter buffer: a driver predicts each
// cycle's registered result from a slot-array model, a monitor checks it.
module tb_demux_1xx_to_40xx_reg;

    localparam int W = 8;

    logic            clk;
    logic            rst;
    logic            wr_en;
    logic [5:0]      wr_select;
    logic [W-1:0]    wr_data;
    logic            wr_ready;
    logic [39:0]     consume;
    logic [40*W-1:0] out;
    logic [39:0]     out_valid;
    logic [5:0]      occupancy;
    logic            err_select;

    demux_1xx_to_40xx_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_select  (wr_select),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .consume    (consume),
        .out        (out),
        .out_valid  (out_valid),
        .occupancy  (occupancy),
        .err_select (err_select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0]     valid;
        logic [40*W-1:0] data;
        logic [5:0]      occ;
        logic            err;
    } exp_t;

    exp_t q_exp[$];

    // Behavioural model: plain slot arrays.
    bit         m_valid [40];
    logic [7:0] m_data  [40];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [40*W-1:0] act, input logic [40*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drives one cycle, checks wr_ready, predicts result.
    task automatic step(input bit r, input bit we, input logic [5:0] s,
                        input logic [7:0] d, input logic [39:0] c);
        bit   rdy;
        int   cnt;
        exp_t e;
        rst = r; wr_en = we; wr_select = s; wr_data = d; consume = c;
        #1;
        rdy = (s < 40) && (!m_valid[s] || c[s]);
        chk("wr_ready", {319'd0, wr_ready}, {319'd0, rdy});
        if (r) begin
            for (int i = 0; i < 40; i++) begin
                m_valid[i] = 0;
                m_data[i]  = 8'h00;
            end
            e.err = 1'b0;
        end else begin
            for (int i = 0; i < 40; i++) if (c[i]) m_valid[i] = 0;
            if (we && rdy) begin
                m_valid[s] = 1;
                m_data[s]  = d;
            end
            e.err = we && (s >= 40);
        end
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            e.valid[i]        = m_valid[i];
            e.data[i*W +: W]  = m_data[i];
            cnt += int'(m_valid[i]);
        end
        e.occ = 6'(cnt);
        q_exp.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 6'd0, 8'h00, 40'd0);
    endtask

    // Monitor: after each rising edge, compare registered outputs to the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() != 0) begin
                e = q_exp.pop_front();
                chk("out_valid",  {280'd0, out_valid},  {280'd0, e.valid});
                chk("out",        out,                  e.data);
                chk("occupancy",  {314'd0, occupancy},  {314'd0, e.occ});
                chk("err_select", {319'd0, err_select}, {319'd0, e.err});
            end
        end
    end

    initial begin
        logic [39:0] c;
        rst = 1'b1; wr_en = 1'b0; wr_select = '0; wr_data = '0; consume = '0;
        for (int i = 0; i < 40; i++) begin
            m_valid[i] = 0;
            m_data[i]  = 8'h00;
        end
        @(negedge clk);

        // Reset then idle, sweeping every select to probe wr_ready.
        step(1, 0, 6'd0, 8'h00, 40'd0);
        step(1, 0, 6'd0, 8'h00, 40'd0);
        for (int s = 0; s < 64; s++) step(0, 0, 6'(s), 8'h00, 40'd0);

        // Fill all slots with 0xA0+i.
        for (int i = 0; i < 40; i++) step(0, 1, 6'(i), 8'(8'hA0 + i), 40'd0);
        idle();

        // Release everything at once, then consume already-empty slots.
        step(0, 0, 6'd0, 8'h00, 40'hFF_FFFF_FFFF);
        step(0, 0, 6'd0, 8'h00, 40'hFF_FFFF_FFFF);
        step(0, 0, 6'd0, 8'h00, 40'h00_0000_0021);

        // Back-pressure on slot 5, then refill in the consume cycle.
        step(0, 1, 6'd5, 8'h11, 40'd0);
        step(0, 1, 6'd5, 8'h22, 40'd0);
        step(0, 1, 6'd5, 8'h22, 40'd1 << 5);
        idle();

        // Illegal selects back to back.
        step(0, 1, 6'd40, 8'h77, 40'd0);
        step(0, 1, 6'd63, 8'h88, 40'd0);
        idle();
        idle();

        // Reset mid-operation with 10 slots valid and a same-cycle write.
        step(0, 0, 6'd0, 8'h00, 40'hFF_FFFF_FFFF);
        for (int i = 0; i < 10; i++) step(0, 1, 6'(i + 20), 8'($urandom_range(0, 255)), 40'd0);
        step(1, 1, 6'd12, 8'h5A, 40'd0);
        step(0, 1, 6'd12, 8'h6B, 40'd0);
        idle();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            c = '0;
            for (int i = 0; i < 40; i++) c[i] = ($urandom_range(0, 7) == 0);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 6'($urandom_range(0, 47)), 8'($urandom_range(0, 255)), c);
        end
        idle();

        repeat (2) @(negedge clk);
        n_checks++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", q_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
